// File: rtl/fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : fifo_pkg                                                   |
// | Description : Shared constants and pointer helpers for the async FIFO    |
// |               pointer blocks (default depth, binary-to-gray conversion). |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package fifo_pkg;

  // Default number of FIFO entries (power of two).
  localparam int c_default_depth = 128;

  // Widest pointer the helper below handles. Callers zero-extend into it and
  // truncate the result. This is exact because the low bits of
  // (x >> 1) ^ x depend only on the low bits of x plus one zero above them.
  localparam int c_max_ptr_w = 32;

  function automatic logic [c_max_ptr_w-1:0] bin2gray(input logic [c_max_ptr_w-1:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_2_bin.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gray_2_bin                                                 |
// | Description : Combinational gray-to-binary pointer conversion.           |
// |               Each binary bit is the XOR of all gray bits at or above it.|
// | Ports       : i_gray [PTR_SIZE:0]  gray-coded pointer in                 |
// |               o_bin  [PTR_SIZE:0]  binary pointer out                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module gray_2_bin #(
  parameter int DEPTH    = 128,
  parameter int PTR_SIZE = $clog2(DEPTH)
) (
  input  logic [PTR_SIZE:0] i_gray,
  output logic [PTR_SIZE:0] o_bin
);

  for (genvar i = 0; i <= PTR_SIZE; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[PTR_SIZE:i];
  end

endmodule
`default_nettype wire

// File: rtl/ptr_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ptr_sync                                                   |
// | Description : SYNC_STAGES-deep flop chain carrying a gray pointer across |
// |               a clock boundary. Plain flops only, so a gray value that   |
// |               changes one bit at a time can never resolve to a pointer   |
// |               that was never driven.                                     |
// | Ports       : clk       destination clock                                |
// |               rst       asynchronous active-high reset                   |
// |               i_d       gray pointer from the source domain              |
// |               o_q       last stage (synchronized pointer)                |
// |               o_q_pen   penultimate stage (value o_q loads next edge)    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ptr_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_q_pen
);

  logic [WIDTH-1:0] r_wq [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_wq[i] <= '0;
      end
    end else begin
      r_wq[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_wq[i] <= r_wq[i-1];
      end
    end
  end

  assign o_q     = r_wq[SYNC_STAGES-1];
  assign o_q_pen = r_wq[SYNC_STAGES-2];

endmodule
`default_nettype wire

// File: rtl/rd_pointer_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rd_pointer_sync                                            |
// | Description : Read-domain pointer manager of the async FIFO. Brings the  |
// |               gray write pointer into r_clk, keeps the binary and gray   |
// |               read pointers and produces registered empty, almost_empty, |
// |               fill level and underflow.                                  |
// | Ports       : r_clk         read-domain clock                            |
// |               r_reset       asynchronous active-high reset               |
// |               rd_en         read request (accepted only when !empty)     |
// |               g_wr_ptr      gray write pointer from the write domain     |
// |               b_rd_ptr      binary read pointer (low bits = address)     |
// |               g_rd_ptr      gray read pointer to the write domain        |
// |               empty         registered empty flag                        |
// |               almost_empty  registered, fill level <= AE_THRESH          |
// |               rd_count      registered fill level, 0..DEPTH              |
// |               underflow     rd_en while empty                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rd_pointer_sync
  import fifo_pkg::*;
#(
  parameter int DEPTH       = c_default_depth,
  parameter int PTR_SIZE    = $clog2(DEPTH),
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 4
) (
  input  logic              r_clk,
  input  logic              r_reset,
  input  logic              rd_en,
  input  logic [PTR_SIZE:0] g_wr_ptr,
  output logic [PTR_SIZE:0] b_rd_ptr,
  output logic [PTR_SIZE:0] g_rd_ptr,
  output logic              empty,
  output logic              almost_empty,
  output logic [PTR_SIZE:0] rd_count,
  output logic              underflow
);

  localparam int c_ptr_w = PTR_SIZE + 1;

  logic [PTR_SIZE:0] r_b_rd_ptr;
  logic [PTR_SIZE:0] r_g_rd_ptr;
  logic [PTR_SIZE:0] r_rd_count;
  logic              r_empty;
  logic              r_almost_empty;
  logic              r_underflow;

  logic              w_rd_fire;
  logic [PTR_SIZE:0] w_b_rd_next;
  logic [PTR_SIZE:0] w_g_rd_next;
  logic [PTR_SIZE:0] w_wq_pen;
  logic [PTR_SIZE:0] w_b_wr_next;
  logic [PTR_SIZE:0] w_cnt_next;
  logic              w_ae_next;

  // The last stage itself is not consumed: every flag is computed from the
  // value it is about to load, so the flags land in step with it.
  ptr_sync #(
    .WIDTH       (c_ptr_w),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wr_ptr_sync (
    .clk     (r_clk),
    .rst     (r_reset),
    .i_d     (g_wr_ptr),
    .o_q     (),
    .o_q_pen (w_wq_pen)
  );

  gray_2_bin #(
    .DEPTH    (DEPTH),
    .PTR_SIZE (PTR_SIZE)
  ) u_wr_gray_2_bin (
    .i_gray (w_wq_pen),
    .o_bin  (w_b_wr_next)
  );

  assign w_rd_fire   = rd_en & ~r_empty;
  assign w_b_rd_next = r_b_rd_ptr + c_ptr_w'(w_rd_fire);
  assign w_g_rd_next = c_ptr_w'(bin2gray(c_max_ptr_w'(w_b_rd_next)));

  // Modular difference of next-cycle pointers: a read and a newly arrived
  // write pointer landing on the same edge both fold into one value, so
  // neither event is lost.
  assign w_cnt_next  = w_b_wr_next - w_b_rd_next;
  assign w_ae_next   = (w_cnt_next <= c_ptr_w'(AE_THRESH));

  always_ff @(posedge r_clk or posedge r_reset) begin
    if (r_reset) begin
      r_b_rd_ptr     <= '0;
      r_g_rd_ptr     <= '0;
      r_rd_count     <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_underflow    <= 1'b0;
    end else begin
      r_b_rd_ptr     <= w_b_rd_next;
      r_g_rd_ptr     <= w_g_rd_next;
      r_rd_count     <= w_cnt_next;
      r_empty        <= (w_cnt_next == '0);
      r_almost_empty <= w_ae_next;
      r_underflow    <= rd_en & r_empty;
    end
  end

  assign b_rd_ptr     = r_b_rd_ptr;
  assign g_rd_ptr     = r_g_rd_ptr;
  assign rd_count     = r_rd_count;
  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_rd_pointer_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rd_pointer_sync                                         |
// | Description : Self-checking bench for rd_pointer_sync (DEPTH=128,        |
// |               SYNC_STAGES=2, AE_THRESH=4). Expected outputs are queued   |
// |               as stimulus is planned and compared after each edge.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_rd_pointer_sync;

  logic       r_clk = 1'b0;
  logic       r_reset = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] g_wr_ptr = 8'h00;
  logic [7:0] b_rd_ptr;
  logic [7:0] g_rd_ptr;
  logic       empty;
  logic       almost_empty;
  logic [7:0] rd_count;
  logic       underflow;

  always #5 r_clk = ~r_clk;

  rd_pointer_sync #(
    .DEPTH       (128),
    .PTR_SIZE    (7),
    .SYNC_STAGES (2),
    .AE_THRESH   (4)
  ) dut (
    .r_clk        (r_clk),
    .r_reset      (r_reset),
    .rd_en        (rd_en),
    .g_wr_ptr     (g_wr_ptr),
    .b_rd_ptr     (b_rd_ptr),
    .g_rd_ptr     (g_rd_ptr),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_count     (rd_count),
    .underflow    (underflow)
  );

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic       e;
    logic       ae;
    logic [7:0] cnt;
    logic       uf;
  } obs_t;

  obs_t       exp_q[$];
  logic       rd_q[$];
  logic [7:0] bw_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] bw = 8'h00;

  function automatic logic [7:0] gray(input logic [7:0] x);
    return (x >> 1) ^ x;
  endfunction

  function automatic obs_t mk(input logic [7:0] b, input logic e, input logic ae,
                              input logic [7:0] cnt, input logic uf);
    return '{b, gray(b), e, ae, cnt, uf};
  endfunction

  function automatic obs_t sample();
    return '{b_rd_ptr, g_rd_ptr, empty, almost_empty, rd_count, underflow};
  endfunction

  // Drive inputs on the falling edge, return just after the next rising edge.
  task automatic tick(input logic rd);
    @(negedge r_clk);
    rd_en    = rd;
    g_wr_ptr = gray(bw);
    @(posedge r_clk);
    #1;
  endtask

  task automatic plan(input logic rd, input logic [7:0] wr, input obs_t ex);
    rd_q.push_back(rd);
    bw_q.push_back(wr);
    exp_q.push_back(ex);
  endtask

  task automatic test_reset();
    obs_t ex, ob;
    @(posedge r_clk);
    #1;
    exp_q.push_back(mk(8'd0, 1'b1, 1'b1, 8'd0, 1'b0));
    ex = exp_q.pop_front(); ob = sample(); n_cmp++;
    if (ob !== ex) begin n_err++; $display("FAIL reset_initial: got %h want %h", ob, ex); end
    @(negedge r_clk);
    r_reset = 1'b0;
    bw = 8'd3;
    tick(1'b0); tick(1'b0); tick(1'b0);
    tick(1'b1);
    exp_q.push_back(mk(8'd1, 1'b0, 1'b1, 8'd2, 1'b0));
    ex = exp_q.pop_front(); ob = sample(); n_cmp++;
    if (ob !== ex) begin n_err++; $display("FAIL reset_preload: got %h want %h", ob, ex); end
    // Mid-cycle assertion must clear outputs before any clock edge.
    #2;
    r_reset  = 1'b1;
    bw       = 8'd0;
    g_wr_ptr = 8'h00;
    #1;
    exp_q.push_back(mk(8'd0, 1'b1, 1'b1, 8'd0, 1'b0));
    ex = exp_q.pop_front(); ob = sample(); n_cmp++;
    if (ob !== ex) begin n_err++; $display("FAIL reset_async: got %h want %h", ob, ex); end
    for (int i = 0; i < 2; i++) begin
      tick(1'b1);
      exp_q.push_back(mk(8'd0, 1'b1, 1'b1, 8'd0, 1'b0));
      ex = exp_q.pop_front(); ob = sample(); n_cmp++;
      if (ob !== ex) begin n_err++; $display("FAIL reset_hold[%0d]: got %h want %h", i, ob, ex); end
    end
    @(negedge r_clk);
    rd_en   = 1'b0;
    r_reset = 1'b0;
  endtask

  task automatic run_plan(input string name);
    obs_t ex, ob;
    int   n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      bw = bw_q.pop_front();
      tick(rd_q.pop_front());
      ex = exp_q.pop_front(); ob = sample(); n_cmp++;
      if (ob !== ex) begin n_err++; $display("FAIL %s[%0d]: got %h want %h", name, i, ob, ex); end
    end
  endtask

  task automatic test_single_write();
    plan(1'b0, 8'd1, mk(8'd0, 1'b1, 1'b1, 8'd0, 1'b0));
    plan(1'b0, 8'd1, mk(8'd0, 1'b0, 1'b1, 8'd1, 1'b0));
    plan(1'b0, 8'd1, mk(8'd0, 1'b0, 1'b1, 8'd1, 1'b0));
    run_plan("single_write");
  endtask

  task automatic test_read_out();
    plan(1'b1, 8'd1, mk(8'd1, 1'b1, 1'b1, 8'd0, 1'b0));
    plan(1'b1, 8'd1, mk(8'd1, 1'b1, 1'b1, 8'd0, 1'b1));
    plan(1'b0, 8'd1, mk(8'd1, 1'b1, 1'b1, 8'd0, 1'b0));
    run_plan("read_out");
  endtask

  task automatic test_almost_empty();
    // Six entries ahead of b_rd_ptr=1.
    plan(1'b0, 8'd7, mk(8'd1, 1'b1, 1'b1, 8'd0, 1'b0));
    plan(1'b0, 8'd7, mk(8'd1, 1'b0, 1'b0, 8'd6, 1'b0));
    for (int k = 1; k <= 6; k++) begin
      plan(1'b1, 8'd7, mk(8'(1 + k), (k == 6), ((6 - k) <= 4), 8'(6 - k), 1'b0));
    end
    plan(1'b1, 8'd7, mk(8'd7, 1'b1, 1'b1, 8'd0, 1'b1));
    plan(1'b0, 8'd7, mk(8'd7, 1'b1, 1'b1, 8'd0, 1'b0));
    run_plan("almost_empty");
  endtask

  task automatic test_wrap();
    obs_t ex, ob;
    // Sweep b_rd_ptr from 7 up to 255 in two 124-entry chunks.
    for (int c = 0; c < 2; c++) begin
      bw = bw + 8'd124;
      tick(1'b0); tick(1'b0);
      repeat (124) tick(1'b1);
    end
    tick(1'b0);
    exp_q.push_back(mk(8'd255, 1'b1, 1'b1, 8'd0, 1'b0));
    ex = exp_q.pop_front(); ob = sample(); n_cmp++;
    if (ob !== ex) begin n_err++; $display("FAIL wrap_preload: got %h want %h", ob, ex); end
    // Write pointer wraps to 3: four entries ahead of 255.
    plan(1'b0, 8'd3, mk(8'd255, 1'b1, 1'b1, 8'd0, 1'b0));
    plan(1'b0, 8'd3, mk(8'd255, 1'b0, 1'b1, 8'd4, 1'b0));
    for (int k = 1; k <= 4; k++) begin
      plan(1'b1, 8'd3, mk(8'(255 + k), (k == 4), 1'b1, 8'(4 - k), 1'b0));
    end
    run_plan("wrap");
  endtask

  task automatic test_full_level();
    // b_rd_ptr=3; write side moves a full DEPTH ahead.
    plan(1'b0, 8'd131, mk(8'd3, 1'b1, 1'b1, 8'd0,   1'b0));
    plan(1'b0, 8'd131, mk(8'd3, 1'b0, 1'b0, 8'd128, 1'b0));
    plan(1'b1, 8'd131, mk(8'd4, 1'b0, 1'b0, 8'd127, 1'b0));
    plan(1'b0, 8'd132, mk(8'd4, 1'b0, 1'b0, 8'd127, 1'b0));
    // New write pointer reaches the lookahead stage on the same edge as a read.
    plan(1'b1, 8'd132, mk(8'd5, 1'b0, 1'b0, 8'd127, 1'b0));
    plan(1'b0, 8'd132, mk(8'd5, 1'b0, 1'b0, 8'd127, 1'b0));
    run_plan("full_level");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_out();
    test_almost_empty();
    test_wrap();
    test_full_level();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
